// File: rtl/camera_capture_ctrl.sv
// OV7670 capture sequencer: recovers frame/line timing from vsync/href, pairs
// bytes into RGB565 words and drives the frame-buffer write port.
module camera_capture_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic        writeClk,
  input  logic        reset,
  input  logic        vsync,
  input  logic        href,
  input  logic [7:0]  camData,
  input  logic        freeze,
  input  logic        singleShot,
  output logic [9:0]  inX,
  output logic [8:0]  inY,
  output logic [15:0] pixelIn,
  output logic        writeEn,
  output logic        frameDone,
  output logic [7:0]  frameCount,
  output logic        lineErr,
  output logic        capturing
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SYNC   = 2'd1;
  localparam logic [1:0] ACTIVE = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;

  localparam logic [9:0] H_LIM = 10'(H_ACTIVE);
  localparam logic [8:0] V_LIM = 9'(V_ACTIVE);

  logic [1:0]  stateReg;
  logic        vsyncD1Reg, vsyncD2Reg, hrefD1Reg, hrefD2Reg;
  logic [7:0]  dataD1Reg;
  logic [9:0]  xReg;
  logic [8:0]  yReg;
  logic        phaseReg;
  logic [7:0]  hiByteReg;
  logic        oneShotReg;
  logic        wrPendReg;
  logic [9:0]  wrXReg;
  logic [8:0]  wrYReg;
  logic [15:0] wrPixReg;

  logic vsyncRise, vsyncFall, hrefFall, inBounds;

  assign vsyncRise = vsyncD1Reg & ~vsyncD2Reg;
  assign vsyncFall = ~vsyncD1Reg & vsyncD2Reg;
  assign hrefFall  = ~hrefD1Reg & hrefD2Reg;
  assign inBounds  = (xReg < H_LIM) && (yReg < V_LIM);
  assign capturing = (stateReg == ACTIVE);

  always_ff @(posedge writeClk) begin
    if (reset) begin
      vsyncD1Reg <= 1'b0;
      vsyncD2Reg <= 1'b0;
      hrefD1Reg  <= 1'b0;
      hrefD2Reg  <= 1'b0;
      dataD1Reg  <= 8'd0;
    end else begin
      vsyncD1Reg <= vsync;
      vsyncD2Reg <= vsyncD1Reg;
      hrefD1Reg  <= href;
      hrefD2Reg  <= hrefD1Reg;
      dataD1Reg  <= camData;
    end
  end

  always_ff @(posedge writeClk) begin
    if (reset) begin
      stateReg   <= IDLE;
      xReg       <= 10'd0;
      yReg       <= 9'd0;
      phaseReg   <= 1'b0;
      hiByteReg  <= 8'd0;
      oneShotReg <= 1'b0;
      wrPendReg  <= 1'b0;
      wrXReg     <= 10'd0;
      wrYReg     <= 9'd0;
      wrPixReg   <= 16'd0;
      writeEn    <= 1'b0;
      inX        <= 10'd0;
      inY        <= 9'd0;
      pixelIn    <= 16'd0;
      frameDone  <= 1'b0;
      frameCount <= 8'd0;
      lineErr    <= 1'b0;
    end else begin
      frameDone <= 1'b0;
      wrPendReg <= 1'b0;
      // Address stage trails the counters so inX/inY line up with the write strobe.
      wrXReg    <= xReg;
      wrYReg    <= yReg;
      writeEn   <= wrPendReg;
      inX       <= wrXReg;
      inY       <= wrYReg;
      if (wrPendReg) pixelIn <= wrPixReg;

      case (stateReg)
        IDLE: if (vsyncRise) stateReg <= SYNC;
        SYNC: if (vsyncFall) stateReg <= ACTIVE;
        ACTIVE: begin
          if (hrefD1Reg) begin
            if (!phaseReg) begin
              hiByteReg <= dataD1Reg;
              phaseReg  <= 1'b1;
            end else begin
              phaseReg  <= 1'b0;
              wrPixReg  <= {hiByteReg, dataD1Reg};
              wrPendReg <= inBounds;
              if (xReg < H_LIM) xReg <= xReg + 10'd1;
            end
          end
          if (hrefFall) begin
            if (xReg != H_LIM || phaseReg) lineErr <= 1'b1;
            xReg     <= 10'd0;
            phaseReg <= 1'b0;
            if (yReg < V_LIM) yReg <= yReg + 9'd1;
          end
          // Frame end overrides the line-end counter update in the same cycle.
          if (vsyncRise) begin
            frameDone  <= 1'b1;
            frameCount <= frameCount + 8'd1;
            xReg       <= 10'd0;
            yReg       <= 9'd0;
            phaseReg   <= 1'b0;
            if (freeze || oneShotReg) begin
              stateReg   <= HOLD;
              oneShotReg <= 1'b0;
            end else begin
              stateReg <= SYNC;
            end
          end
        end
        HOLD: begin
          if (!freeze) begin
            stateReg   <= SYNC;
            oneShotReg <= 1'b0;
          end else if (singleShot) begin
            stateReg   <= SYNC;
            oneShotReg <= 1'b1;
          end
        end
        default: stateReg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_camera_capture_ctrl.sv
// Randomized capture bench: a frame-level model predicts every write and frame
// completion; a monitor process checks them as the DUT produces them.
module tb_camera_capture_ctrl;

  localparam int H = 8;
  localparam int V = 4;
  localparam int IDLE_M = 0, RUN_M = 1, HELD_M = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vsync = 1'b0;
  logic        href = 1'b0;
  logic [7:0]  camData = 8'd0;
  logic        freeze = 1'b0;
  logic        singleShot = 1'b0;
  logic [9:0]  inX;
  logic [8:0]  inY;
  logic [15:0] pixelIn;
  logic        writeEn;
  logic        frameDone;
  logic [7:0]  frameCount;
  logic        lineErr;
  logic        capturing;

  camera_capture_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .writeClk(clk), .reset(reset), .vsync(vsync), .href(href),
    .camData(camData), .freeze(freeze), .singleShot(singleShot),
    .inX(inX), .inY(inY), .pixelIn(pixelIn), .writeEn(writeEn),
    .frameDone(frameDone), .frameCount(frameCount), .lineErr(lineErr),
    .capturing(capturing)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [15:0] pix;
    logic [9:0]  x;
    logic [8:0]  y;
    int          cyc;
  } wr_t;
  typedef struct {
    int         cyc;
    logic [7:0] cnt;
  } fd_t;

  wr_t wrQ[$];
  fd_t fdQ[$];

  int checks = 0;
  int errors = 0;

  // Frame-level model state
  int         mode = IDLE_M;
  bit         curCap = 1'b0;
  bit         expLineErr = 1'b0;
  bit         hrefHeld = 1'b0;
  int         lastLen = 0;
  logic [7:0] expCount = 8'd0;
  logic [7:0] hiByte = 8'd0;
  int         frameNo = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe from the DUT consumes one predicted transaction.
  bit prevWe = 1'b0;
  always @(posedge clk) begin
    #1;
    if (writeEn) begin
      check("we_rate", {31'd0, prevWe}, 32'd0);
      if (wrQ.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        wr_t e;
        e = wrQ.pop_front();
        check("wr_x", {22'd0, inX}, {22'd0, e.x});
        check("wr_y", {23'd0, inY}, {23'd0, e.y});
        check("wr_pix", {16'd0, pixelIn}, {16'd0, e.pix});
        check("wr_cycle", cyc, e.cyc);
      end
    end
    prevWe = writeEn;
    if (frameDone) begin
      if (fdQ.size() == 0) begin
        check("unexpected_frameDone", 32'd1, 32'd0);
      end else begin
        fd_t f;
        f = fdQ.pop_front();
        check("fd_cycle", cyc, f.cyc);
        check("fd_count", {24'd0, frameCount}, {24'd0, f.cnt});
        $display("frameDone cycle=%0d frameCount=%0d lineErr=%0b", cyc, frameCount, lineErr);
      end
    end
  end

  task automatic lineEndModel(input int n);
    if (curCap && ((n / 2) < H || (n % 2) != 0)) expLineErr = 1'b1;
  endtask

  task automatic boundaryModel(input int ec);
    if (curCap) begin
      fd_t f;
      expCount = expCount + 8'd1;
      f.cyc = ec;
      f.cnt = expCount;
      fdQ.push_back(f);
      mode = freeze ? HELD_M : RUN_M;
    end
    if (mode == IDLE_M) begin
      mode   = RUN_M;
      curCap = 1'b1;
    end else begin
      curCap = (mode == RUN_M);
    end
  endtask

  task automatic vsyncPulse();
    @(negedge clk);
    check("lineErr", {31'd0, lineErr}, {31'd0, expLineErr});
    if (hrefHeld) begin
      href = 1'b0;
      lineEndModel(lastLen);
      hrefHeld = 1'b0;
    end
    vsync = 1'b1;
    boundaryModel(cyc + 2);
    repeat (4) @(negedge clk);
    vsync = 1'b0;
    repeat (4) @(negedge clk);
    check("capturing", {31'd0, capturing}, {31'd0, curCap});
  endtask

  task automatic sendLine(input int n, input int y, input bit endSame, input bit directed);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      href = 1'b1;
      if (directed && i == 0)      b = 8'hF8;
      else if (directed && i == 1) b = 8'h1F;
      else                         b = 8'($urandom);
      camData = b;
      if ((i % 2) == 0) begin
        hiByte = b;
      end else if (curCap && (i / 2) < H && y < V) begin
        wr_t e;
        e.pix = {hiByte, b};
        e.x   = 10'(i / 2);
        e.y   = 9'(y);
        e.cyc = cyc + 3;
        wrQ.push_back(e);
      end
    end
    if (endSame) begin
      hrefHeld = 1'b1;
      lastLen  = n;
    end else begin
      @(negedge clk);
      href = 1'b0;
      lineEndModel(n);
      repeat (4) @(negedge clk);
    end
  endtask

  // act: 1 freeze on, 2 singleShot, 3 freeze off with singleShot, 5 reset
  task automatic doAction(input int act);
    case (act)
      1: freeze = 1'b1;
      2: begin
        @(negedge clk);
        singleShot = 1'b1;
        if (mode == HELD_M && freeze) mode = RUN_M;
        @(negedge clk);
        singleShot = 1'b0;
      end
      3: begin
        @(negedge clk);
        freeze = 1'b0;
        singleShot = 1'b1;
        if (mode == HELD_M) mode = RUN_M;
        @(negedge clk);
        singleShot = 1'b0;
      end
      5: begin
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mode = IDLE_M;
        curCap = 1'b0;
        expLineErr = 1'b0;
        expCount = 8'd0;
        check("rst_writeEn", {31'd0, writeEn}, 32'd0);
        check("rst_frameDone", {31'd0, frameDone}, 32'd0);
        check("rst_frameCount", {24'd0, frameCount}, 32'd0);
        check("rst_lineErr", {31'd0, lineErr}, 32'd0);
        check("rst_capturing", {31'd0, capturing}, 32'd0);
        check("rst_inX", {22'd0, inX}, 32'd0);
        check("rst_inY", {23'd0, inY}, 32'd0);
        check("rst_pixelIn", {16'd0, pixelIn}, 32'd0);
      end
      default: ;
    endcase
  endtask

  // kind: 0 clean, 1 short/long lines, 2 clean with fixed first pixel
  task automatic frame(input int nLines, input int kind, input int actLine,
                       input int act, input bit endSame);
    int len;
    vsyncPulse();
    frameNo++;
    $display("frame %0d start captured=%0b freeze=%0b", frameNo, curCap, freeze);
    for (int l = 0; l < nLines; l++) begin
      if (l == actLine) doAction(act);
      len = 2 * H;
      if (kind == 1 && l == 0) len = 2 * H - 1;
      if (kind == 1 && l == 1) len = 2 * H + 6;
      sendLine(len, l, endSame && (l == nLines - 1), kind == 2 && l == 0);
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("init_writeEn", {31'd0, writeEn}, 32'd0);
    check("init_frameCount", {24'd0, frameCount}, 32'd0);
    check("init_lineErr", {31'd0, lineErr}, 32'd0);
    check("init_capturing", {31'd0, capturing}, 32'd0);
    check("init_pixelIn", {16'd0, pixelIn}, 32'd0);
    repeat (3) @(negedge clk);

    frame(V, 2, -1, 0, 1'b0);
    frame(V, 0, -1, 0, 1'b0);
    frame(V + 1, 1, -1, 0, 1'b0);
    frame(V, 0, -1, 0, 1'b0);
    frame(V, 0, 2, 2, 1'b0);
    frame(V, 0, 2, 1, 1'b0);
    frame(V, 0, -1, 0, 1'b0);
    frame(V, 0, -1, 0, 1'b0);
    frame(V, 0, 1, 2, 1'b0);
    frame(V, 0, -1, 0, 1'b0);
    frame(V, 0, -1, 0, 1'b0);
    frame(V, 0, 1, 3, 1'b0);
    frame(V, 0, -1, 0, 1'b0);
    frame(V, 0, -1, 0, 1'b0);
    frame(V, 0, 2, 5, 1'b0);
    for (int i = 0; i < 256; i++) frame(V, 0, -1, 0, i == 255);
    vsyncPulse();
    repeat (6) @(negedge clk);

    check("wrap_frameCount", {24'd0, frameCount}, 32'd0);
    check("model_count", {24'd0, frameCount}, {24'd0, expCount});
    check("edge_inY", {23'd0, inY}, 32'd0);
    check("edge_inX", {22'd0, inX}, 32'd0);
    check("wrQ_empty", wrQ.size(), 32'd0);
    check("fdQ_empty", fdQ.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
